// File: rtl/service_gate_pkg.sv
// service_gate_pkg: phase encoding and request decode helpers for service_gate_seq
package service_gate_pkg;

    typedef enum logic [1:0] {IDLE, RT, CT, WT} phase_e;

    function automatic logic [31:0] sc_decode(input logic en, input logic [31:0] addr, input logic [31:0] nreg);
        return (en && addr < nreg) ? 32'd1 << addr : 32'd0;
    endfunction

    function automatic logic multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/sgs_phase_ctr.sv
// sgs_phase_ctr: IDLE->RT->CT->WT sequencer, each phase PH_CYC clocks long
module sgs_phase_ctr
    import service_gate_pkg::*;
#(
    parameter int PH_CYC = 2
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_start,
    output phase_e o_phase,
    output phase_e o_nxt,
    output logic   o_last,
    output logic   o_busy
);
    localparam int CW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;

    phase_e        r_phase;
    phase_e        w_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last  = r_cnt == CW'(PH_CYC - 1);
    assign o_phase = r_phase;
    assign o_nxt   = w_nxt;
    assign o_busy  = r_phase != IDLE;
    assign o_last  = w_last && o_busy;

    // a start on the final WT clock chains straight into the next RT
    always_comb begin
        w_nxt = r_phase;
        if (r_phase == IDLE)
            w_nxt = i_start ? RT : IDLE;
        else if (w_last)
            w_nxt = (r_phase == RT) ? CT : (r_phase == CT) ? WT : i_start ? RT : IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_nxt;
            r_cnt   <= (r_phase == IDLE || w_last) ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/service_gate_seq.sv
// service_gate_seq: time-pulse read/clear/write gating of central registers with carry-in flip-flop
module service_gate_seq
    import service_gate_pkg::*;
#(
    parameter int NREG   = 8,
    parameter int NCH    = 8,
    parameter int PH_CYC = 2,
    parameter int U_IDX  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                                  SIM_CLK,
    input  logic                                  SIM_RST,
    input  logic                                  TP_START,
    input  logic [NREG-1:0]                       RD_REQ,
    input  logic [NREG-1:0]                       WR_REQ,
    input  logic                                  RSC,
    input  logic                                  WSC,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] SC_ADDR,
    input  logic                                  GINH,
    input  logic                                  CI_REQ,
    input  logic                                  CINORM,
    output logic [NREG-1:0]                       RG_n,
    output logic [NREG-1:0]                       CG,
    output logic [NREG-1:0]                       WG_n,
    output logic                                  CI_n,
    output logic                                  BUSY,
    output logic                                  RCONT,
    output logic                                  SC_MISS,
    output logic                                  OVR,
    output logic [CNT_W-1:0]                      TP_COUNT
);
    phase_e            w_phase, w_nxt;
    logic              w_last, w_busy, w_acc;
    logic [NREG-1:0]   w_rd_new, w_wr_new, w_wmask;
    logic [NREG-1:0]   r_rd, r_wr, r_rg_n, r_cg, r_wg_n;
    logic              r_ginh, r_ci, r_ciff, r_rcont, r_miss, r_ovr;
    logic [CNT_W-1:0]  r_cnt;

    sgs_phase_ctr #(.PH_CYC(PH_CYC)) u_ctr (
        .i_clk   (SIM_CLK),
        .i_rst   (SIM_RST),
        .i_start (TP_START),
        .o_phase (w_phase),
        .o_nxt   (w_nxt),
        .o_last  (w_last),
        .o_busy  (w_busy)
    );

    assign w_acc    = TP_START && (w_phase == IDLE || (w_phase == WT && w_last));
    assign w_rd_new = RD_REQ | NREG'(sc_decode(RSC, 32'(SC_ADDR), 32'(NREG)));
    assign w_wr_new = WR_REQ | NREG'(sc_decode(WSC, 32'(SC_ADDR), 32'(NREG)));
    assign w_wmask  = r_wr & ~{NREG{r_ginh}};

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_ginh  <= 1'b0;
            r_ci    <= 1'b0;
            r_rcont <= 1'b0;
            r_miss  <= 1'b0;
            r_rg_n  <= '1;
            r_cg    <= '0;
            r_wg_n  <= '1;
            r_ovr   <= 1'b0;
            r_ciff  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_acc) begin
                r_rd    <= w_rd_new;
                r_wr    <= w_wr_new;
                r_ginh  <= GINH;
                r_ci    <= CI_REQ;
                r_rcont <= multi_hot(32'(w_rd_new));
                r_miss  <= (RSC | WSC) && 32'(SC_ADDR) >= 32'(NREG);
            end
            r_rg_n <= (w_nxt == RT) ? ~(w_acc ? w_rd_new : r_rd) : '1;
            r_cg   <= (w_nxt == CT) ? w_wmask : '0;
            r_wg_n <= (w_nxt == WT) ? ~w_wmask : '1;
            r_ovr  <= TP_START && w_busy && !w_acc;
            // a carry-in requested in this pulse outlives the U clear of the same pulse
            r_ciff <= (w_acc && CI_REQ) ? 1'b1 :
                      (w_phase == CT && w_last && r_cg[U_IDX] && !r_ci) ? 1'b0 : r_ciff;
            if (w_phase == WT && w_last)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign RG_n     = r_rg_n;
    assign CG       = r_cg;
    assign WG_n     = r_wg_n;
    assign CI_n     = ~(r_ciff | CINORM);
    assign BUSY     = w_busy;
    assign RCONT    = r_rcont;
    assign SC_MISS  = r_miss;
    assign OVR      = r_ovr;
    assign TP_COUNT = r_cnt;
endmodule

// File: doc/service_gate_seq.md
Name: service_gate_seq

Overview:
- Parametrised successor to the fixed-width central-register service gating logic.
- Splits each time pulse into three phases: read (RT), clear (CT) and write (WT). Each phase is a programmable number of clocks.
- Drives one-hot read, clear and write gate vectors for NREG central registers. Special-channel read/write (RSC/WSC) is decoded onto those same vectors.
- Holds the carry-in flip-flop (CIFF) and reports bus contention, missed channel addresses and time-pulse overruns for the monitor.

Parameters:
- NREG, 8: number of gated central registers (2..32).
- NCH, 8: size of the special-channel address space (NCH >= 1).
- PH_CYC, 2: clocks per phase (>= 1).
- U_IDX, 3: index of the adder output register U. Clearing it releases the carry-in flip-flop.
- CNT_W, 16: width of the time-pulse counter.

Ports:
- SIM_CLK  in  1  system clock.
- SIM_RST  in  1  reset.
- TP_START  in  1  one-clock strobe that begins a time pulse and samples all requests.
- RD_REQ  in  NREG  read control pulses, any number may be set.
- WR_REQ  in  NREG  write control pulses.
- RSC  in  1  special-channel read request.
- WSC  in  1  special-channel write request.
- SC_ADDR  in  max(1,$clog2(NCH))  special-channel address.
- GINH  in  1  write inhibit.
- CI_REQ  in  1  set carry-in flip-flop.
- CINORM  in  1  normal carry-in, combinational OR term.
- RG_n  out  NREG  read gates, active low.
- CG  out  NREG  clear gates, active high.
- WG_n  out  NREG  write gates, active low.
- CI_n  out  1  carry-in to adder, active low.
- BUSY  out  1  time pulse in progress.
- RCONT  out  1  more than one read gate set this pulse.
- SC_MISS  out  1  channel address >= NREG requested.
- OVR  out  1  TP_START arrived while busy.
- TP_COUNT  out  CNT_W  completed time pulses.

Behaviour:
- Clock and reset: one clock, SIM_CLK. SIM_RST is synchronous and active-high.
- Reset values:
  - FSM IDLE.
  - RG_n and WG_n all ones; CG all zeros.
  - CIFF=0, so CI_n = ~CINORM.
  - BUSY, RCONT, SC_MISS, OVR all 0; TP_COUNT 0.
- Reset mid-pulse: every gate drops on the next edge and the pulse is not counted.
- FSM states: IDLE -> RT -> CT -> WT -> IDLE.
  - Each non-IDLE state lasts exactly PH_CYC clocks (phase counter).
  - TP_START in IDLE latches the request vectors and enters RT on the next edge.
  - BUSY=1 in RT, CT and WT.
  - One pulse lasts 3*PH_CYC clocks.
  - TP_START on the last WT clock is accepted; the FSM goes WT -> RT with no IDLE gap.
- Latched vectors, taken at TP_START:
  - rd = RD_REQ | (RSC && SC_ADDR<NREG ? onehot(SC_ADDR) : 0)
  - wr = WR_REQ | (WSC && SC_ADDR<NREG ? onehot(SC_ADDR) : 0)
  - ginh = GINH
  - When RSC and WSC are both set, both decodes apply to the same address.
- Gates, all registered (outputs change on the edge that enters the phase):
  - RG_n = ~rd while in RT.
  - CG = wr & {NREG{~ginh}} while in CT.
  - WG_n = ~(wr & {NREG{~ginh}}) while in WT.
  - All gates are inactive in every other state.
- GINH suppresses clear and write only; reads proceed.
- Status flags, each registered at TP_START and held until the next accepted TP_START or reset:
  - RCONT = popcount(rd) > 1.
  - SC_MISS = (RSC|WSC) && SC_ADDR >= NREG. The missed address produces no gate.
- Overrun: TP_START while BUSY, other than on the last WT clock, is ignored. OVR pulses for 1 clock and the latched requests stay unchanged.
- Carry-in flip-flop (CIFF):
  - CI_REQ is latched at TP_START and sets CIFF on entry to RT.
  - CIFF clears on the last CT clock when CG[U_IDX] is asserted.
  - If the same pulse both sets and clears CIFF, the set wins, so CIFF stays 1.
  - CI_n = ~(CIFF | CINORM), combinational.
- TP_COUNT increments on WT exit and wraps modulo 2^CNT_W.

Decomposition:
- Package service_gate_pkg holds:
  - the phase enum (IDLE, RT, CT, WT);
  - a function that returns the one-hot decode with range check;
  - a function that returns popcount > 1.
- One sub-module, sgs_phase_ctr: the phase FSM plus the PH_CYC counter. It outputs the phase, a last-clock flag and BUSY.
- Request latching, gate drive, CIFF and status logic stay in the top level.

Test Plan:
- Reset, then TP_START with RD_REQ=8'h04 and WR_REQ=8'h10, PH_CYC=2:
  - RG_n=8'hFB for clocks 1-2.
  - CG=8'h10 for clocks 3-4.
  - WG_n=8'hEF for clocks 5-6.
  - Idle at clock 7; TP_COUNT=1.
- GINH=1 with WR_REQ=8'h01 and RD_REQ=8'h02: RG_n=8'hFD in RT; CG stays 0 and WG_n stays 8'hFF throughout.
- WSC=1 with SC_ADDR=5 (NREG=8): CG[5] and then WG_n[5] assert. Repeat with NREG=4 and SC_ADDR=5: SC_MISS=1 and no gates assert.
- RD_REQ=8'h03: RCONT=1 and both read gates are active. A second TP_START in CT gives OVR=1 for 1 clock; the gates are unchanged.
- CI_REQ=1 in pulse A (CI_n=0 from RT), then WR_REQ[U_IDX] in pulse B: CI_n returns to 1 after the last CT clock of B. Asserting CI_REQ and clearing U in the same pulse leaves CI_n=0.
- Back-to-back: TP_START on the last WT clock gives RT on the next clock with no IDLE gap. SIM_RST asserted mid-CT gives all gates inactive next clock, BUSY=0 and TP_COUNT=0.
